ex_muldiv: RTL and testbench

Execute-stage multiply/divide unit with the architectural HI/LO registers for the Minisys-1A pipeline. It consumes the EX-side operands and decode fields produced by the ID/EX pipeline register. MULT/MULTU and MTHI/MTLO complete in one cycle. DIV/DIVU run as a 32-iteration restoring divider and raise a stall request to the hazard unit until HI/LO hold the result.

---
 rtl/ex_muldiv.sv | 123 ++++++++++++
 tb/tb_ex_muldiv.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply/divide unit with HI/LO (cpu_clk, reset, op_valid/func/dataA/dataB/mthi/mtlo/flush in; stall_req/busy/hi/lo/div_by_zero out)
module ex_muldiv (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [5:0]  func,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_raw_q, a_raw_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d, sgn_q, sgn_d;
  logic        div_by_zero_q, div_by_zero_d;
  logic        is_signed, is_mul, is_div, ge, dz;
  logic [63:0] ax, bx, prod;
  logic [31:0] sub, q_fix, r_fix;
  assign is_signed = ~func[0];
  assign is_mul    = op_valid && (func == 6'h18 || func == 6'h19);
  assign is_div    = op_valid && (func == 6'h1A || func == 6'h1B);
  assign ax        = {{32{is_signed & dataA[31]}}, dataA};
  assign bx        = {{32{is_signed & dataB[31]}}, dataB};
  assign prod      = ax * bx;
  assign ge        = {rem_q, quo_q[31]} >= {1'b0, dvs_q};
  assign sub       = {rem_q[30:0], quo_q[31]} - dvs_q;
  assign q_fix     = (sgn_q && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
  assign r_fix     = (sgn_q && sign_a_q) ? -rem_q : rem_q;
  assign dz        = dvs_q == 32'd0;
  assign stall_req = !reset && !flush &&
                     ((state_q == IDLE && is_div) || state_q == DIV || state_q == FIX);
  assign busy        = state_q == DIV || state_q == FIX;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = div_by_zero_q;
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    a_raw_d       = a_raw_q;
    sign_a_d      = sign_a_q;
    sign_b_d      = sign_b_q;
    sgn_d         = sgn_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    div_by_zero_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          hi_d = is_mul ? prod[63:32] : (mthi ? dataA : hi_q);
          lo_d = is_mul ? prod[31:0] : (mtlo ? dataA : lo_q);
          if (is_div) begin
            state_d  = DIV;
            count_d  = 5'd0;
            rem_d    = 32'd0;
            sgn_d    = is_signed;
            sign_a_d = is_signed & dataA[31];
            sign_b_d = is_signed & dataB[31];
            quo_d    = (is_signed & dataA[31]) ? -dataA : dataA;
            dvs_d    = (is_signed & dataB[31]) ? -dataB : dataB;
            a_raw_d  = dataA;
          end
        end
        DIV: begin
          // quo_q shifts the dividend out of its MSB while quotient bits enter at the LSB
          rem_d   = ge ? sub : {rem_q[30:0], quo_q[31]};
          quo_d   = {quo_q[30:0], ge};
          count_d = count_q + 5'd1;
          state_d = count_q == 5'd31 ? FIX : DIV;
        end
        FIX: begin
          lo_d          = dz ? 32'hFFFF_FFFF : q_fix;
          hi_d          = dz ? a_raw_q : r_fix;
          div_by_zero_d = dz;
          state_d       = DONE;
        end
        DONE: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= 5'd0;
      rem_q         <= 32'd0;
      quo_q         <= 32'd0;
      dvs_q         <= 32'd0;
      a_raw_q       <= 32'd0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      sgn_q         <= 1'b0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      a_raw_q       <= a_raw_d;
      sign_a_q      <= sign_a_d;
      sign_b_q      <= sign_b_d;
      sgn_q         <= sgn_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv with a behavioural HI/LO model
module tb_ex_muldiv;
  logic        cpu_clk = 0, reset = 1, op_valid = 0, mthi = 0, mtlo = 0, flush = 0;
  logic [5:0]  func = 0;
  logic [31:0] dataA = 0, dataB = 0;
  logic        stall_req, busy, div_by_zero;
  logic [31:0] hi, lo;

  ex_muldiv dut (
    .cpu_clk(cpu_clk), .reset(reset), .op_valid(op_valid), .func(func),
    .dataA(dataA), .dataB(dataB), .mthi(mthi), .mtlo(mtlo), .flush(flush),
    .stall_req(stall_req), .busy(busy), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [31:0] hi, lo;
    logic        dz;
    int          stalls, busy;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          checks = 0, passed = 0;
  logic        ex_valid = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  int          ns = 0, nb = 0;
  logic        mdz;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // kinds: 0 nop, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MTHI+MTLO
  // flush_at: EX cycle (0 = first) in which flush is raised, -1 for none
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input string nm);
    exp_t        e;
    logic [63:0] p;
    bit          dv, fl;
    logic        st;
    dv = kind == 3 || kind == 4;
    fl = dv ? (flush_at >= 0 && flush_at <= 33) : flush_at == 0;
    if (!fl) begin
      case (kind)
        1: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
        2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
        3: begin
          if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_hi = 0; m_lo = a; end
          else begin m_lo = $signed(a) / $signed(b); m_hi = $signed(a) % $signed(b); end
        end
        4: begin
          if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
          else begin m_lo = a / b; m_hi = a % b; end
        end
        5: m_hi = a;
        6: m_lo = a;
        7: begin m_hi = a; m_lo = a; end
        default: ;
      endcase
    end
    e.hi = m_hi; e.lo = m_lo; e.dz = dv && !fl && b == 0;
    e.stalls = dv ? (fl ? flush_at : 34) : 0;
    e.busy = dv ? (fl ? flush_at : 33) : 0;
    e.name = nm;
    @(negedge cpu_clk);
    ex_valid = 1;
    op_valid = kind >= 1 && kind <= 4;
    func = kind == 1 ? 6'h18 : kind == 2 ? 6'h19 : kind == 3 ? 6'h1A : kind == 4 ? 6'h1B : 6'h00;
    mthi = kind == 5 || kind == 7;
    mtlo = kind == 6 || kind == 7;
    dataA = a; dataB = b;
    flush = flush_at == 0;
    q.push_back(e);
    for (int n = 0; ; n++) begin
      #1 st = stall_req;
      @(posedge cpu_clk);
      if (!st) break;
      if (n == 60) begin
        checks++;
        $display("FAIL %s timeout: stall_req still 1 after %0d cycles, required release by 34", nm, n);
        break;
      end
      @(negedge cpu_clk);
      if (n + 1 == flush_at) flush = 1;
    end
  endtask

  // monitor: an instruction leaves EX at the edge ending a cycle with stall_req low
  always begin
    @(negedge cpu_clk);
    #2;
    if (!ex_valid) begin
      ns = 0; nb = 0;
    end else begin
      nb += int'(busy);
      if (stall_req) ns++;
      else begin
        mdz = div_by_zero;
        @(posedge cpu_clk);
        #1;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL retire_unexpected: got retirement, required none pending");
        end else begin
          me = q.pop_front();
          chk({me.name, "_hi"}, hi, me.hi);
          chk({me.name, "_lo"}, lo, me.lo);
          chk({me.name, "_dz"}, mdz, me.dz);
          chk({me.name, "_stalls"}, ns, me.stalls);
          chk({me.name, "_busy"}, nb, me.busy);
        end
        ns = 0; nb = 0;
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    int kind, fa;
    repeat (2) @(negedge cpu_clk);
    #2;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall_req, 0);
    chk("reset_dz", div_by_zero, 0);
    reset = 0;
    issue(1, 32'hFFFF_FFFE, 32'd3, -1, "mult");
    issue(2, 32'hFFFF_FFFE, 32'd3, -1, "multu");
    issue(3, 32'hFFFF_FFF9, 32'd2, -1, "div_neg7_2");
    issue(4, 32'd100, 32'd7, -1, "divu_100_7");
    issue(4, 32'd5, 32'd0, -1, "divu_by0");
    issue(3, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
    issue(3, 32'hFFFF_1234, 32'd0, -1, "div_by0");
    issue(5, 32'hDEAD_BEEF, 32'd0, -1, "mthi");
    issue(6, 32'h1234_5678, 32'd0, -1, "mtlo");
    issue(3, 32'd1000, 32'hFFFF_FFF9, -1, "div_overwrite");
    issue(5, 32'h1111_1111, 32'd0, -1, "mthi_pre");
    issue(6, 32'h2222_2222, 32'd0, -1, "mtlo_pre");
    issue(3, 32'd99, 32'd5, 20, "div_flush20");
    issue(6, 32'h3333_3333, 32'd0, 0, "mtlo_flush");
    issue(1, 32'h7FFF_FFFF, 32'h8000_0000, 0, "mult_flush");
    issue(4, 32'hFFFF_FFFF, 32'd1, -1, "divu_max");
    @(negedge cpu_clk);
    ex_valid = 0; op_valid = 1; func = 6'h1A; dataA = 32'd77; dataB = 32'd3;
    mthi = 0; mtlo = 0; flush = 0;
    repeat (10) @(negedge cpu_clk);
    #2;
    chk("middiv_busy", busy, 1);
    reset = 1;
    #1;
    chk("async_reset_hi", hi, 0);
    chk("async_reset_lo", lo, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_stall", stall_req, 0);
    m_hi = 0; m_lo = 0;
    @(negedge cpu_clk);
    reset = 0; op_valid = 0;
    issue(4, 32'd100, 32'd7, -1, "after_reset");
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 7);
      a = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom;
      b = $urandom_range(0, 5) == 0 ? 32'd0 : ($urandom_range(0, 1) == 1 ? $urandom : $urandom_range(1, 100));
      if (kind == 3 && $urandom_range(0, 3) == 0) b = 32'hFFFF_FFFF;
      fa = $urandom_range(0, 7) == 0 ? $urandom_range(0, 33) : -1;
      issue(kind, a, b, fa, "rand");
    end
    @(negedge cpu_clk);
    ex_valid = 0; op_valid = 0; mthi = 0; mtlo = 0; flush = 0;
    repeat (3) @(negedge cpu_clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
